apb_ram_ws: RTL and testbench

Parametrised APB3 slave SRAM, the next generation of the team's single-cycle APB RAM peripheral on the RISC-V APB bus. It adds configurable data width, depth and wait states, byte-lane write strobes (PSTRB) and an error response (PSLVERR) for out-of-range or misaligned accesses. It sits behind the APB master/decoder as one PSEL slot.

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_ram_mem.sv | 41 ++++
 rtl/apb_ram_ws.sv | 110 +++++++++++
 tb/tb_apb_ram_ws.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types, response codes and geometry helpers for the wait-stated APB SRAM slave.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_ram_state_e;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

  // Byte-offset bits inside one data word.
  function automatic int ofs_f(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word-index bits needed to address the storage array.
  function automatic int idx_w_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Geometry of the default 32-bit x 1024-word configuration.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 1024;
  localparam int OFS        = ofs_f(DEF_DATA_W);
  localparam int IDX_W      = idx_w_f(DEF_DEPTH);

endpackage

// File: rtl/apb_ram_mem.sv
// Single-port SRAM with per-byte write enables and a registered, clearable read port.
module apb_ram_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic                re_i,
  input  logic                rclr_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array itself is never reset so it maps onto block RAM; only the read register clears.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || rclr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_ram_ws.sv
// APB3 SRAM slave with configurable wait states, byte strobes and PSLVERR on bad addresses.
module apb_ram_ws
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  input  logic                PWRITE,
  input  logic                PSEL,
  input  logic                PENABLE,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int OFS_B    = ofs_f(DATA_W);
  localparam int IDX_FULL = ADDR_W - OFS_B;
  localparam int MEM_AW   = idx_w_f(DEPTH);
  localparam int CNT_W    = 4;

  apb_ram_state_e      state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                pready_q;
  logic                pslverr_q;

  logic [IDX_FULL-1:0] idx;
  logic                addr_err;
  logic                done_d;
  logic [DATA_W/8-1:0] mem_we;
  logic                mem_re;
  logic                mem_rclr;

  assign idx      = PADDR[ADDR_W-1:OFS_B];
  assign addr_err = (32'(idx) >= 32'(DEPTH)) || (PADDR[OFS_B-1:0] != '0);

  // The edge that enters DONE is the one that commits the write or captures the read.
  always_comb begin
    done_d = 1'b0;
    unique case (state_q)
      IDLE:    done_d = PSEL && PENABLE && (WAIT_STATES == 0);
      WAIT:    done_d = PSEL && (cnt_q == '0);
      default: done_d = 1'b0;
    endcase
  end

  assign mem_we   = (done_d && PWRITE && !addr_err && !PRESET) ? PSTRB : '0;
  assign mem_re   = done_d && !PWRITE && !addr_err;
  assign mem_rclr = done_d && !PWRITE && addr_err;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= APB_OKAY;
    end else begin
      // NOTE: defaults first, then the DONE entry below overrides them (last non-blocking write wins).
      pready_q  <= 1'b0;
      pslverr_q <= APB_OKAY;
      unique case (state_q)
        IDLE: begin
          if (PSEL && PENABLE && (WAIT_STATES != 0)) begin
            cnt_q   <= CNT_W'(WAIT_STATES - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (done_d) begin
        state_q   <= DONE;
        pready_q  <= 1'b1;
        pslverr_q <= addr_err ? APB_ERR : APB_OKAY;
      end
    end
  end

  apb_ram_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (MEM_AW)
  ) u_mem (
    .clk_i   (PCLK),
    .rst_i   (PRESET),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .rclr_i  (mem_rclr),
    .addr_i  (idx[MEM_AW-1:0]),
    .wdata_i (PWDATA),
    .rdata_o (PRDATA)
  );

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_ram_ws.sv
// Directed and scoreboarded random bench for apb_ram_ws with zero and three wait states.
module tb_apb_ram_ws;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [12:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PWRITE;
  logic        PENABLE;
  logic        psel0, psel3;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  int errors = 0;
  int checks = 0;

  always #5 PCLK = ~PCLK;

  apb_ram_ws #(.ADDR_W(13), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PWRITE(PWRITE), .PSEL(psel0), .PENABLE(PENABLE),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  apb_ram_ws #(.ADDR_W(13), .DATA_W(32), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PWRITE(PWRITE), .PSEL(psel3), .PENABLE(PENABLE),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One APB transfer; cyc counts edges from the first access cycle until PREADY is seen.
  task automatic xfer(input bit use3, input bit wr, input logic [12:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic er, output int cyc);
    logic rdy;
    tick();
    check("ready_outside_access", use3 ? pready3 : pready0, 1'b0);
    PADDR = a; PWDATA = wd; PSTRB = st; PWRITE = wr; PENABLE = 1'b0;
    psel0 = !use3; psel3 = use3;
    tick();
    PENABLE = 1'b1;
    rdy = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      tick();
      rdy = use3 ? pready3 : pready0;
      if (rdy) break;
    end
    if (!rdy) check("ready_timeout", rdy, 1'b1);
    rd = use3 ? prdata3 : prdata0;
    er = use3 ? pslverr3 : pslverr0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, wd, last_rd, exp_rd;
    logic        er, exp_err, wr, seen;
    logic [12:0] a;
    logic [3:0]  st;
    logic [31:0] model [16];
    int          cyc, w, sel;

    PRESET = 1'b1; PADDR = '0; PWDATA = '0; PSTRB = '0; PWRITE = 1'b0;
    PENABLE = 1'b0; psel0 = 1'b0; psel3 = 1'b0;
    tick(); tick();
    PRESET = 1'b0;
    check("rst_prdata0", prdata0, 32'h0);
    check("rst_pready0", pready0, 1'b0);
    check("rst_pslverr0", pslverr0, 1'b0);
    check("rst_pready3", pready3, 1'b0);

    // Zero wait states: basic write/read and 3-cycle transfer
    xfer(0, 1, 13'h004, 32'hDEAD_BEEF, 4'hF, rd, er, cyc);
    check("wr004_err", er, 1'b0);
    check("wr004_latency", 32'(cyc), 32'd1);
    xfer(0, 0, 13'h004, 32'h0, 4'h0, rd, er, cyc);
    check("rd004_data", rd, 32'hDEAD_BEEF);
    check("rd004_err", er, 1'b0);
    check("rd004_latency", 32'(cyc), 32'd1);

    // Byte strobes
    xfer(0, 1, 13'h010, 32'h1122_3344, 4'hF, rd, er, cyc);
    xfer(0, 1, 13'h010, 32'hAABB_CCDD, 4'h5, rd, er, cyc);
    check("wr_strb_prdata_hold", rd, 32'hDEAD_BEEF);
    xfer(0, 0, 13'h010, 32'h0, 4'h0, rd, er, cyc);
    check("rd010_strb", rd, 32'h11BB_33DD);

    // Zero strobe write changes nothing
    xfer(0, 1, 13'h004, 32'h0, 4'h0, rd, er, cyc);
    check("wr_strb0_err", er, 1'b0);
    xfer(0, 0, 13'h004, 32'h0, 4'h0, rd, er, cyc);
    check("rd004_after_strb0", rd, 32'hDEAD_BEEF);

    // Depth boundary and error responses
    xfer(0, 1, 13'h000, 32'hCAFE_F00D, 4'hF, rd, er, cyc);
    xfer(0, 1, 13'h0FFC, 32'h0102_0304, 4'hF, rd, er, cyc);
    check("wr_last_word_err", er, 1'b0);
    xfer(0, 0, 13'h0FFC, 32'h0, 4'h0, rd, er, cyc);
    check("rd_last_word", rd, 32'h0102_0304);
    xfer(0, 0, 13'h1000, 32'h0, 4'h0, rd, er, cyc);
    check("rd_oor_err", er, 1'b1);
    check("rd_oor_data", rd, 32'h0);
    xfer(0, 1, 13'h002, 32'hFFFF_FFFF, 4'hF, rd, er, cyc);
    check("wr_misaligned_err", er, 1'b1);
    xfer(0, 0, 13'h000, 32'h0, 4'h0, rd, er, cyc);
    check("rd000_no_corrupt", rd, 32'hCAFE_F00D);
    check("rd000_err", er, 1'b0);

    // Three wait states
    xfer(1, 1, 13'h020, 32'h1234_5678, 4'hF, rd, er, cyc);
    check("ws3_wr_latency", 32'(cyc), 32'd4);
    xfer(1, 0, 13'h020, 32'h0, 4'h0, rd, er, cyc);
    check("ws3_rd_latency", 32'(cyc), 32'd4);
    check("ws3_rd_data", rd, 32'h1234_5678);

    // Abort: PSEL dropped in the second WAIT cycle
    tick();
    PADDR = 13'h020; PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF; PWRITE = 1'b1;
    PENABLE = 1'b0; psel0 = 1'b0; psel3 = 1'b1;
    tick(); PENABLE = 1'b1;
    tick();
    tick(); psel3 = 1'b0; PENABLE = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen |= pready3;
    end
    check("abort_no_ready", seen, 1'b0);
    check("abort_prdata_hold", prdata3, 32'h1234_5678);
    xfer(1, 0, 13'h020, 32'h0, 4'h0, rd, er, cyc);
    check("abort_no_write", rd, 32'h1234_5678);

    // Reset asserted during WAIT of a write
    tick();
    PADDR = 13'h020; PWDATA = 32'h0000_0055; PSTRB = 4'hF; PWRITE = 1'b1;
    PENABLE = 1'b0; psel0 = 1'b0; psel3 = 1'b1;
    tick(); PENABLE = 1'b1;
    tick();
    tick(); PRESET = 1'b1;
    tick();
    check("midrst_prdata", prdata3, 32'h0);
    check("midrst_pready", pready3, 1'b0);
    check("midrst_pslverr", pslverr3, 1'b0);
    PRESET = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
    xfer(1, 0, 13'h020, 32'h0, 4'h0, rd, er, cyc);
    check("midrst_write_dropped", rd, 32'h1234_5678);

    // Random back-to-back traffic on a 16-word window plus bad addresses
    last_rd = 32'h0;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model[i] = wd;
      xfer(0, 1, 13'(i * 4), wd, 4'hF, rd, er, cyc);
      check("init_prdata_hold", rd, last_rd);
    end
    for (int n = 0; n < 1000; n++) begin
      sel = $urandom_range(0, 9);
      w   = $urandom_range(0, 15);
      if (sel < 7)       a = 13'(w * 4);
      else if (sel == 7) a = 13'(w * 4 + $urandom_range(1, 3));
      else               a = 13'h1000 | 13'($urandom_range(0, 4095));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      exp_err = (a[1:0] != 2'b00) || a[12];
      xfer(0, wr, a, wd, st, rd, er, cyc);
      check("rnd_err", er, exp_err);
      check("rnd_latency", 32'(cyc), 32'd1);
      if (wr) begin
        check("rnd_wr_prdata_hold", rd, last_rd);
        if (!exp_err) begin
          for (int b = 0; b < 4; b++) begin
            if (st[b]) model[a[5:2]][8*b +: 8] = wd[8*b +: 8];
          end
        end
      end else begin
        exp_rd = exp_err ? 32'h0 : model[a[5:2]];
        check("rnd_rd_data", rd, exp_rd);
        last_rd = exp_rd;
      end
    end
    tick();
    check("final_ready_low", pready0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
